mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter: XLEN, default 32, operand width; result width is 2*XLEN.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 start  in  1  Execute-stage request to begin a long multiply/divide.
REQ-005 op  in  2  00 UMULL, 01 SMULL, 10 UDIV, 11 SDIV.
REQ-006 src_a / src_b  in  XLEN each  multiplicand/dividend, multiplier/divisor (post-forwarding).
REQ-007 rd_lo / rd_hi  in  4 each  destination registers: low half / quotient, high half / remainder.
REQ-008 flush  in  1  kill in-flight operation (branch taken in Writeback).
REQ-009 busy  out  1  operation in flight.
REQ-010 stall  out  1  to hazard unit; freezes Fetch/Decode/Execute.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 result  out  2*XLEN  {hi, lo} or {remainder, quotient}.
REQ-013 wa3 / wa3_2  out  4 each  write addresses for regfile ports 1 and 2.
REQ-014 reg_write  out  2  bit0 enables the wa3 write, bit1 the wa3_2 write.

Function
REQ-015 FSM states: IDLE, PREP, RUN, FIX, DONE.
REQ-016 IDLE->PREP when start=1 and flush=0; op, rd_lo and rd_hi are latched in that cycle.
REQ-017 PREP (1 cycle): take magnitudes of signed operands, record result signs; divisor==0 -> DONE directly.
REQ-018 RUN: exactly XLEN iterations, counter 0..XLEN-1; multiply is radix-2 shift-add, divide is restoring.
REQ-019 FIX (1 cycle): negate the product if operand signs differ (SMULL); for SDIV, negate the quotient if signs differ and give the remainder the dividend's sign.
REQ-020 DONE (1 cycle): done=1, result valid, reg_write asserted; then -> IDLE.
REQ-021 Latency: done is high exactly XLEN+3 cycles after the start-accept edge (35 for XLEN=32); divide-by-zero gives 3.
REQ-022 Divide by zero: quotient all-ones, remainder = src_a, in both unsigned and signed modes.
REQ-023 SDIV of INT_MIN by -1: quotient 0x80000000, remainder 0.
REQ-024 reg_write=2'b11 in DONE; if rd_hi==rd_lo, reg_write=2'b01 and only the low half/quotient is written; reg_write=2'b00 in all other states.
REQ-025 wa3=latched rd_lo, wa3_2=latched rd_hi; both hold until the next accepted start.
REQ-026 result holds its value after DONE until the next accepted start.
REQ-027 busy=1 in all states except IDLE.
REQ-028 stall=(IDLE and start and not flush) or state in {PREP, RUN, FIX}; stall=0 in DONE so the pipeline advances.
REQ-029 start while busy is ignored; start and flush in the same cycle in IDLE is ignored.
REQ-030 flush in PREP/RUN/FIX -> IDLE on the next edge, with no done and no reg_write; flush in DONE does not suppress completion.

Reset
REQ-031 reset low forces IDLE asynchronously.
REQ-032 Under reset: busy=0, done=0, reg_write=2'b00, result=0, wa3=0, wa3_2=0, counter=0.
REQ-033 stall=0 under reset regardless of start.
REQ-034 Reset asserted mid-operation discards the operation; the first start after reset release behaves as from power-up.

Structure
REQ-035 Shared package mdu_pkg holds: op encodings, FSM state enum, DIV_ZERO_Q constant (all-ones).
REQ-036 Sub-module mdu_step holds one iteration of combinational shift-add / restoring-subtract logic; the sequencer owns the FSM, counter and registers.
REQ-037 No multiplier or divider primitives; the iterative datapath only.

Verification
REQ-038 UMULL 0xFFFFFFFF*0xFFFFFFFF, rd_lo=2, rd_hi=3 -> done at cycle 35; result 0xFFFFFFFE_00000001; reg_write=11; wa3=2; wa3_2=3.
REQ-039 SMULL -3*7 -> result 0xFFFFFFFF_FFFFFFEB; stall high from the accept cycle through FIX, low in DONE.
REQ-040 SDIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; UDIV 10/0 -> done at cycle 3, quotient 0xFFFFFFFF, remainder 10.
REQ-041 Flush at RUN iteration 10 of a UMULL -> IDLE next cycle; no done; reg_write never set; next start accepted and correct.
REQ-042 reset driven low at RUN iteration 20 -> all outputs zero immediately; after release, UDIV 100/7 -> quotient 14, remainder 2.
REQ-043 Same-register and ignored-start cases: rd_hi=rd_lo=5 -> reg_write=01; start pulses while busy -> no effect on result or latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the long multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_UMULL = 2'b00,
    OP_SMULL = 2'b01,
    OP_UDIV  = 2'b10,
    OP_SDIV  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  // Quotient returned for a zero divisor; sliced to XLEN by the user.
  localparam int unsigned DIV_ZERO_W = 64;
  localparam logic [DIV_ZERO_W-1:0] DIV_ZERO_Q = '1;

  // Bit 1 of the op selects divide, bit 0 selects signed operands.
  function automatic logic op_is_div(mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(mdu_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative datapath: radix-2 shift-add multiply or
// restoring divide. {i_hi, i_lo} is the working pair, i_b the multiplicand
// or divisor (always an unsigned magnitude here).
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  // Multiply: add multiplicand on lo[0], then shift the pair right.
  // Divide: shift the pair left, trial-subtract, keep the difference if it
  // did not borrow. The partial remainder is always below the divisor, so
  // the top bit of the difference is a clean borrow flag.
  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_shift = {i_hi, i_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_b};
    w_ge    = ~w_diff[XLEN];
    if (i_is_div) begin
      o_hi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle long multiply / divide unit with pipeline stall handshake.
//
// state | meaning
// IDLE  | waiting for start; operands, op and destinations latched on accept
// PREP  | take magnitudes, record result signs, detect divide-by-zero
// RUN   | XLEN iterations of shift-add or restoring subtract
// FIX   | apply signs (or the divide-by-zero result), load result register
// DONE  | one-cycle completion: done, reg_write, pipeline released
//
// Divide-by-zero skips RUN and goes PREP -> FIX -> DONE, so completion comes
// three edges after the accept edge (counting the accept edge itself); a
// normal operation completes XLEN+3 edges after it counted the same way.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,    // active low, asynchronous
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [XLEN-1:0]   i_src_a,
  input  logic [XLEN-1:0]   i_src_b,
  input  logic [3:0]        i_rd_lo,
  input  logic [3:0]        i_rd_hi,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_stall,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_result,
  output logic [3:0]        o_wa3,
  output logic [3:0]        o_wa3_2,
  output logic [1:0]        o_reg_write
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mdu_state_e        r_state;
  mdu_state_e        w_next;
  mdu_op_e           r_op;
  logic [3:0]        r_rd_lo;
  logic [3:0]        r_rd_hi;
  logic [XLEN-1:0]   r_a_raw;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_neg_lo;
  logic              r_neg_rem;
  logic              r_div_zero;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_result;

  logic              w_accept;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [2*XLEN-1:0] w_final;

  assign w_accept = (r_state == ST_IDLE) && i_start && !i_flush;

  mdu_step #(.XLEN(XLEN)) u_step (
    .i_is_div (op_is_div(r_op)),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_b      (r_b),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Operand magnitudes and final sign correction of the working pair.
  always_comb begin
    w_a_neg = op_is_signed(r_op) && r_a_raw[XLEN-1];
    w_b_neg = op_is_signed(r_op) && r_b[XLEN-1];
    w_a_mag = w_a_neg ? -r_a_raw : r_a_raw;
    w_b_mag = w_b_neg ? -r_b : r_b;
    w_prod  = {r_hi, r_lo};
    w_quot  = r_neg_lo  ? -r_lo : r_lo;
    w_rem   = r_neg_rem ? -r_hi : r_hi;
    w_final = r_neg_lo ? -w_prod : w_prod;
    if (op_is_div(r_op)) begin
      w_final = r_div_zero ? {r_a_raw, DIV_ZERO_Q[XLEN-1:0]} : {w_rem, w_quot};
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and status outputs.
  always_comb begin
    w_next      = r_state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_stall     = 1'b0;
    o_reg_write = 2'b00;
    unique case (r_state)
      ST_IDLE: begin
        o_busy  = 1'b0;
        o_stall = w_accept && i_reset;
        if (w_accept) w_next = ST_PREP;
      end
      ST_PREP: begin
        o_stall = 1'b1;
        if (i_flush)                            w_next = ST_IDLE;
        else if (op_is_div(r_op) && r_b == '0)  w_next = ST_FIX;
        else                                    w_next = ST_RUN;
      end
      ST_RUN: begin
        o_stall = 1'b1;
        if (i_flush)                w_next = ST_IDLE;
        else if (r_cnt == CNT_LAST) w_next = ST_FIX;
      end
      ST_FIX: begin
        o_stall = 1'b1;
        w_next  = i_flush ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        o_reg_write = (r_rd_hi == r_rd_lo) ? 2'b01 : 2'b11;
        w_next      = ST_IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath, counter and result registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_op       <= OP_UMULL;
      r_rd_lo    <= '0;
      r_rd_hi    <= '0;
      r_a_raw    <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_neg_lo   <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= mdu_op_e'(i_op);
            r_rd_lo <= i_rd_lo;
            r_rd_hi <= i_rd_hi;
            r_a_raw <= i_src_a;
            r_b     <= i_src_b;
          end
        end
        ST_PREP: begin
          r_hi       <= '0;
          r_lo       <= w_a_mag;
          r_b        <= w_b_mag;
          r_neg_lo   <= w_a_neg ^ w_b_neg;
          r_neg_rem  <= w_a_neg;
          r_div_zero <= op_is_div(r_op) && (r_b == '0);
          r_cnt      <= '0;
        end
        ST_RUN: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (!i_flush) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_wa3    = r_rd_lo;
  assign o_wa3_2  = r_rd_hi;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  rd_lo;
  logic [3:0]  rd_hi;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [63:0] result;
  logic [3:0]  wa3;
  logic [3:0]  wa3_2;
  logic [1:0]  reg_write;

  int n_checks = 0;
  int n_errors = 0;

  mdu_sequencer #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_start     (start),
    .i_op        (op),
    .i_src_a     (src_a),
    .i_src_b     (src_b),
    .i_rd_lo     (rd_lo),
    .i_rd_hi     (rd_hi),
    .i_flush     (flush),
    .o_busy      (busy),
    .o_stall     (stall),
    .o_done      (done),
    .o_result    (result),
    .o_wa3       (wa3),
    .o_wa3_2     (wa3_2),
    .o_reg_write (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [63:0] exp_res;
    int          exp_lat;
    logic [1:0]  exp_rw;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: result from plain arithmetic on the architectural operation.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (mop)
      2'b00: r = {32'h0, a} * {32'h0, b};
      2'b01: r = sa * sb;
      2'b10: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (sa == -64'sd2147483648 && sb == -64'sd1) r = {32'h0, 32'h8000_0000};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] mop, input logic [31:0] b);
    return (mop[1] && b == 0) ? 3 : 35;
  endfunction

  // Issue one operation and check completion; noise toggles start/operands
  // while busy, which must not disturb anything.
  task automatic do_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] lo, input logic [3:0] hi,
                       input logic [63:0] exp_res, input int exp_lat,
                       input logic [1:0] exp_rw, input bit noise, input string tag);
    int cyc;
    bit stall_ok;
    bit rw_early;
    @(negedge clk);
    start = 1'b1; op = mop; src_a = a; src_b = b; rd_lo = lo; rd_hi = hi; flush = 1'b0;
    #1;
    check({tag, "_stall_accept"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    stall_ok = 1'b1;
    rw_early = 1'b0;
    while (!done && cyc < 200) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (reg_write !== 2'b00) rw_early = 1'b1;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        rd_lo = 4'($urandom);
        rd_hi = 4'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_reg_write"}, 64'(reg_write), 64'(exp_rw));
    check({tag, "_wa3"}, 64'(wa3), 64'(lo));
    check({tag, "_wa3_2"}, 64'(wa3_2), 64'(hi));
    check({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
    check({tag, "_stall_done"}, 64'(stall), 64'd0);
    check({tag, "_no_early_write"}, 64'(rw_early), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'({done, busy, reg_write}), 64'd0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [3:0]  rlo, rhi;
    logic [63:0] saved;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 4'd3, 64'hFFFF_FFFE_0000_0001, 35, 2'b11};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'd7,         4'd1, 4'd4, 64'hFFFF_FFFF_FFFF_FFEB, 35, 2'b11};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         4'd6, 4'd7, 64'hFFFF_FFFF_FFFF_FFFD, 35, 2'b11};
    vecs[3]  = '{2'b10, 32'd10,        32'd0,         4'd8, 4'd9, 64'h0000_000A_FFFF_FFFF, 3,  2'b11};
    vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1, 4'd2, 64'h0000_0000_8000_0000, 35, 2'b11};
    vecs[5]  = '{2'b10, 32'd100,       32'd7,         4'd3, 4'd4, 64'h0000_0002_0000_000E, 35, 2'b11};
    vecs[6]  = '{2'b00, 32'd6,         32'd7,         4'd5, 4'd5, 64'h0000_0000_0000_002A, 35, 2'b01};
    vecs[7]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,         4'd10, 4'd11, 64'hFFFF_FFF9_FFFF_FFFF, 3, 2'b11};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 4'd12, 4'd13, 64'h4000_0000_0000_0000, 35, 2'b11};
    vecs[9]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 4'd14, 4'd15, 64'h0000_0001_FFFF_FFFD, 35, 2'b11};
    vecs[10] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         4'd0, 4'd1, 64'h0000_0000_FFFF_FFFF, 35, 2'b11};

    // Reset state with start held high.
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; op = 2'b00;
    src_a = 32'h1234; src_b = 32'h5678; rd_lo = 4'd1; rd_hi = 4'd2;
    #12;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_outputs", {busy, done, reg_write, wa3, wa3_2}, '0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    // start together with flush in IDLE is ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    #1;
    check("start_flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("start_flush_ignored", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi,
            vecs[i].exp_res, vecs[i].exp_lat, vecs[i].exp_rw, (i % 2) == 1,
            $sformatf("vec%0d", i));
    end

    // Flush at RUN iteration 10 of a UMULL.
    saved = result;
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd1000; src_b = 32'd1000; rd_lo = 4'd2; rd_hi = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
      if (reg_write !== 2'b00 || done !== 1'b0) check("flush_pre_write", 64'(reg_write), 64'd0);
    end
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_to_idle", 64'({busy, done, reg_write}), 64'd0);
    repeat (30) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || reg_write !== 2'b00) check("flush_no_done", 64'({done, reg_write}), 64'd0);
    end
    check("flush_result_unchanged", result, saved);
    do_op(2'b00, 32'd1234, 32'd5678, 4'd2, 4'd3, 64'd7006652, 35, 2'b11, 1'b0, "after_flush");

    // Reset at RUN iteration 20 of a UDIV.
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd999; src_b = 32'd5; rd_lo = 4'd7; rd_hi = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    #2;
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {busy, done, stall, reg_write, wa3, wa3_2}, '0);
    check("midreset_result", result, 64'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    do_op(2'b10, 32'd100, 32'd7, 4'd1, 4'd9, {32'd2, 32'd14}, 35, 2'b11, 1'b0, "after_reset");

    // Randomized operations against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom);
      ra  = rand_operand();
      rb  = rand_operand();
      rlo = 4'($urandom);
      rhi = ($urandom_range(0, 3) == 0) ? rlo : 4'($urandom);
      do_op(rop, ra, rb, rlo, rhi, model(rop, ra, rb), model_lat(rop, rb),
            (rlo == rhi) ? 2'b01 : 2'b11, k[0], $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
